// File: rtl/fifo.sv
// Synchronous single-clock packet FIFO.
//
// Stores FIFO_DEPTH packets of W = DATA_LINE_WIDTH + CONTROL_LINE_WIDTH bits.
// Reads have one cycle of latency: o_read_packet loads the oldest entry on the
// edge that accepts the read. When no read is accepted, o_read_packet keeps
// its last value. Overflow and underflow requests are dropped.
//
// Ports
//   clk               : clock, rising edge
//   rst_n             : asynchronous active-low reset
//   i_read_packet_en  : read request
//   i_write_packet_en : write request
//   i_write_packet    : packet to write (W bits)
//   o_read_packet     : registered read data (W bits)
//   o_empty_flag      : occupancy is 0
//   o_full_flag       : occupancy is FIFO_DEPTH
module fifo #(
  parameter int FIFO_DEPTH         = 32,
  parameter int LOG2_FIFO_DEPTH    = 5,
  parameter int DATA_LINE_WIDTH    = 64,
  parameter int CONTROL_LINE_WIDTH = 6
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          i_read_packet_en,
  input  logic                                          i_write_packet_en,
  input  logic [DATA_LINE_WIDTH+CONTROL_LINE_WIDTH-1:0] i_write_packet,
  output logic [DATA_LINE_WIDTH+CONTROL_LINE_WIDTH-1:0] o_read_packet,
  output logic                                          o_empty_flag,
  output logic                                          o_full_flag
);

  localparam int W = DATA_LINE_WIDTH + CONTROL_LINE_WIDTH;
  localparam logic [LOG2_FIFO_DEPTH:0] DEPTH_CNT = (LOG2_FIFO_DEPTH+1)'(FIFO_DEPTH);

  logic [W-1:0]               mem [FIFO_DEPTH];
  logic [LOG2_FIFO_DEPTH-1:0] wr_ptr;
  logic [LOG2_FIFO_DEPTH-1:0] rd_ptr;
  logic [LOG2_FIFO_DEPTH:0]   count;
  logic                       rd_accept;
  logic                       wr_accept;

  assign o_empty_flag = (count == '0);
  assign o_full_flag  = (count == DEPTH_CNT);

  // A full FIFO can still take a write when a read frees a slot on the same
  // edge. An empty FIFO never accepts a read, so a same-cycle write cannot
  // pass straight through to o_read_packet.
  assign rd_accept = i_read_packet_en && !o_empty_flag;
  assign wr_accept = i_write_packet_en && (!o_full_flag || rd_accept);

  // The array has no reset. Entries left over from before a reset cannot be
  // reached until they are written again.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= i_write_packet;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      o_read_packet <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_accept) begin
        // When the FIFO is full, wr_ptr == rd_ptr. This reads the old entry,
        // because the write to the same slot only lands on this edge.
        o_read_packet <= mem[rd_ptr];
        rd_ptr        <= rd_ptr + 1'b1;
      end
      if (wr_accept && !rd_accept) begin
        count <= count + 1'b1;
      end else if (rd_accept && !wr_accept) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo.sv
module tb_fifo;

  localparam int DEPTH = 32;
  localparam int W     = 70;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rd_en;
  logic         wr_en;
  logic [W-1:0] wr_data;
  logic [W-1:0] rd_data;
  logic         empty;
  logic         full;

  fifo dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_read_packet_en  (rd_en),
    .i_write_packet_en (wr_en),
    .i_write_packet    (wr_data),
    .o_read_packet     (rd_data),
    .o_empty_flag      (empty),
    .o_full_flag       (full)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of the stored packets plus the last value read.
  logic [W-1:0] q [$];
  logic [W-1:0] exp_rd;
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_pkt();
    return {6'($urandom), $urandom, $urandom};
  endfunction

  // Drive one cycle of requests, let the clock edge happen, then compare the
  // DUT with the model.
  task automatic step(input logic rd, input logic wr, input logic [W-1:0] d, input string tag);
    bit acc_r;
    bit acc_w;
    rd_en   = rd;
    wr_en   = wr;
    wr_data = d;
    acc_r = rd && (q.size() != 0);
    acc_w = wr && ((q.size() < DEPTH) || acc_r);
    @(posedge clk);
    #1;
    if (acc_r) exp_rd = q.pop_front();
    if (acc_w) q.push_back(d);
    chk({tag, "_empty"}, W'(empty), W'(q.size() == 0));
    chk({tag, "_full"},  W'(full),  W'(q.size() == DEPTH));
    chk({tag, "_data"},  rd_data, exp_rd);
  endtask

  initial begin
    int n;
    rst_n   = 1'b0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    exp_rd  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_empty", W'(empty), W'(1'b1));
    chk("rst_full",  W'(full),  W'(1'b0));
    chk("rst_data",  rd_data,   '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Overflow: writes 32..69 must be dropped.
    for (int i = 0; i < 70; i++) begin
      step(1'b0, 1'b1, W'(i), "ovf");
      if (i == 31) chk("full_after_32", W'(full), W'(1'b1));
    end

    // Drain, then keep reading an empty FIFO.
    for (int i = 0; i < 70; i++) begin
      step(1'b1, 1'b0, '0, "drain");
      if (i < 32) chk("drain_val", rd_data, W'(i));
    end
    chk("drain_hold", rd_data, W'(31));

    // Wrap-around of both pointers.
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, rnd_pkt(), "wrap_w20");
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, '0, "wrap_r20");
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, rnd_pkt(), "wrap_w30");
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, '0, "wrap_r30");

    // Hold the occupancy at 10 with simultaneous read and write.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, rnd_pkt(), "sim_fill");
    for (int i = 0; i < 50; i++) begin
      step(1'b1, 1'b1, rnd_pkt(), "sim");
      chk("sim_count", W'(q.size()), W'(10));
    end
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0, "sim_drain");

    // Empty with simultaneous read and write: only the write is accepted.
    step(1'b1, 1'b1, W'(70'h155), "empty_rw");
    chk("empty_rw_nobypass", W'(empty), W'(1'b0));
    step(1'b1, 1'b0, '0, "empty_rw_rd");
    chk("empty_rw_val", rd_data, W'(70'h155));

    // Full with simultaneous read and write of 0xAA.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, W'(100 + i), "full_fill");
    step(1'b1, 1'b1, W'(70'hAA), "full_rw");
    chk("full_rw_oldest", rd_data, W'(100));
    chk("full_rw_flag",   W'(full), W'(1'b1));
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, '0, "full_drain");
    chk("full_rw_last", rd_data, W'(70'hAA));

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      n = (i / 500) % 3;
      step(($urandom_range(9) < (n == 0 ? 3 : (n == 1 ? 7 : 5))),
           ($urandom_range(9) < (n == 0 ? 7 : (n == 1 ? 3 : 5))),
           rnd_pkt(), "rand");
    end

    // Reset mid-operation at occupancy 15.
    while (q.size() > 15) step(1'b1, 1'b0, '0, "pre_rst_rd");
    while (q.size() < 15) step(1'b0, 1'b1, rnd_pkt(), "pre_rst_wr");
    step(1'b1, 1'b0, '0, "pre_rst_rd1");
    step(1'b0, 1'b1, rnd_pkt(), "pre_rst_wr1");
    #2;
    rst_n = 1'b0;
    q.delete();
    exp_rd = '0;
    #1;
    chk("mid_rst_empty", W'(empty), W'(1'b1));
    chk("mid_rst_full",  W'(full),  W'(1'b0));
    chk("mid_rst_data",  rd_data,   '0);
    #1;
    rst_n = 1'b1;
    step(1'b1, 1'b0, '0, "post_rst_rd");
    step(1'b0, 1'b1, W'(70'h3C), "post_rst_wr");
    step(1'b1, 1'b0, '0, "post_rst_rd2");
    chk("post_rst_val", rd_data, W'(70'h3C));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 32, giving the number of packet entries.
REQ-002 The block SHALL have parameter LOG2_FIFO_DEPTH, default 5, giving the pointer width (log2 of FIFO_DEPTH).
REQ-003 The block SHALL have parameter DATA_LINE_WIDTH, default 64, giving the data field width.
REQ-004 The block SHALL have parameter CONTROL_LINE_WIDTH, default 6, giving the control field width.
REQ-005 Packet width W SHALL be DATA_LINE_WIDTH+CONTROL_LINE_WIDTH (70 by default).
Ports (name, direction, width, meaning):
REQ-006 clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-007 rst_n, input, 1, reset: one clock; reset is asynchronous and active-low.
REQ-008 i_read_packet_en, input, 1, read request.
REQ-009 i_write_packet_en, input, 1, write request.
REQ-010 i_write_packet, input, W, packet to write.
REQ-011 o_read_packet, output, W, registered read data.
REQ-012 o_empty_flag, output, 1, high when the occupancy count is 0.
REQ-013 o_full_flag, output, 1, high when the occupancy count is FIFO_DEPTH.

Function
REQ-014 Storage SHALL be a FIFO_DEPTH x W array.
REQ-015 The array SHALL be addressed by write and read pointers, each LOG2_FIFO_DEPTH bits wide.
REQ-016 An occupancy count of LOG2_FIFO_DEPTH+1 bits SHALL be kept, ranging 0..FIFO_DEPTH.
REQ-017 A write SHALL be accepted when i_write_packet_en=1 and either o_full_flag=0 or a read is accepted in the same cycle.
REQ-018 On an accepted write, i_write_packet SHALL be stored at the write pointer and the write pointer SHALL increment.
REQ-019 A write request while full with no accepted read SHALL be dropped, with no change to storage, pointers or count (overflow protection).
REQ-020 A read SHALL be accepted when i_read_packet_en=1 and o_empty_flag=0.
REQ-021 On an accepted read, o_read_packet SHALL load the entry at the read pointer on that clock edge (1-cycle latency), and the read pointer SHALL increment.
REQ-022 A read request while empty SHALL be ignored (underflow protection); o_read_packet, pointers and count SHALL not change.
REQ-023 When no read is accepted, o_read_packet SHALL hold its last value.
REQ-024 Both pointers SHALL wrap from FIFO_DEPTH-1 to 0 (modulo-2^LOG2_FIFO_DEPTH; FIFO_DEPTH SHALL be a power of two).
REQ-025 Count update: +1 on an accepted write only; -1 on an accepted read only; unchanged when both or neither are accepted.
REQ-026 A simultaneous read and write while empty SHALL accept only the write; the new packet SHALL not bypass to o_read_packet.
REQ-027 A simultaneous read and write while full SHALL accept both; the read SHALL return the oldest entry and the count SHALL stay FIFO_DEPTH.
REQ-028 o_empty_flag and o_full_flag SHALL be decoded combinationally from the registered count, so both reflect the state after the last clock edge.
REQ-029 Packets SHALL be read out in exactly the order they were accepted, bit-exact, with no reordering.

Reset
REQ-030 When rst_n=0, the block SHALL immediately and asynchronously clear both pointers and the count, and set o_read_packet to 0.
REQ-031 During reset, o_empty_flag SHALL be 1 and o_full_flag SHALL be 0.
REQ-032 Array contents SHALL not be reset; after reset they are unreachable until rewritten.
REQ-033 Reset asserted in mid-operation SHALL discard all stored packets.
REQ-034 Normal operation SHALL resume on the first rising clock edge after rst_n deasserts.

Verification
REQ-035 Overflow: write values 0..69 on 70 consecutive cycles from empty. Required: o_full_flag=1 after the 32nd write; only 0..31 are stored; writes of 32..69 are dropped.
REQ-036 Drain/underflow: after REQ-035, assert read for 70 cycles. Required: o_read_packet=0,1,...,31, each 1 cycle after its read; o_empty_flag=1 after the 32nd read; o_read_packet holds 31 thereafter.
REQ-037 Wrap-around: perform 20 writes and 20 reads, then 30 writes and 30 reads. Required: FIFO order is preserved across the pointer wrap, and the flags are correct at each step.
REQ-038 Simultaneous access: hold count at 10 with read and write both asserted for 50 cycles. Required: count stays 10; no flag changes; data stays in order.
REQ-039 Full with simultaneous access: at count 32, assert read and write with value 0xAA. Required: the oldest entry is read out; o_full_flag stays 1; 0xAA is read out last.
REQ-040 Reset mid-operation: pulse rst_n low between clock edges at count 15. Required: empty=1, full=0 and o_read_packet=0 immediately; a following read request is ignored.
